encoder16x4_drain: RTL and testbench

- Sequential 16-to-4 encoder: the inverse of the team's 4-to-16 one-hot decoder.
- Accepts a 16-bit request vector through a valid/ready handshake and latches it.
- Emits the 4-bit index of every set bit, lowest index first, one code per output handshake.
- Sits between one-hot/multi-hot request sources (interrupt lines, grant vectors) and index-based consumers.

---
 rtl/encoder16x4_drain_pkg.sv | 10 +
 rtl/encoder16x4_drain_lsb_encoder16.sv | 22 ++
 rtl/encoder16x4_drain.sv | 84 ++++++++
 tb/tb_encoder16x4_drain.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/encoder16x4_drain_pkg.sv
// Shared widths and FSM encoding for the 16-to-4 draining encoder.
package encoder16x4_drain_pkg;
  localparam int N_IN   = 16;
  localparam int W_CODE = $clog2(N_IN);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/encoder16x4_drain_lsb_encoder16.sv
// Lowest-set-bit encoder: bit 0 has highest priority; also flags nonzero and single-bit vectors.
module lsb_encoder16
  import encoder16x4_drain_pkg::*;
(
  input  logic [N_IN-1:0]   vec,
  output logic [W_CODE-1:0] code,
  output logic              any,
  output logic              single
);

  always_comb begin
    code = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (vec[i]) code = W_CODE'(i);
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - N_IN'(1))) == '0);

endmodule

// File: rtl/encoder16x4_drain.sv
// Accepts a request vector and emits the index of each set bit, lowest first, one per handshake.
module encoder16x4_drain
  import encoder16x4_drain_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_CODE-1:0] out_code,
  output logic              out_last,
  output logic              out_multi,
  output logic              err_zero,
  output logic              busy
);

  state_t            state;
  logic [N_IN-1:0]   pend;
  logic [W_CODE-1:0] pend_code;
  logic              pend_any;
  logic              pend_single;
  logic [W_CODE-1:0] in_code_unused;
  logic              in_any;
  logic              in_single;

  lsb_encoder16 u_pend_enc (
    .vec    (pend),
    .code   (pend_code),
    .any    (pend_any),
    .single (pend_single)
  );

  lsb_encoder16 u_in_enc (
    .vec    (in_vec),
    .code   (in_code_unused),
    .any    (in_any),
    .single (in_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      out_multi <= 1'b0;
      err_zero  <= 1'b0;
    end else begin
      err_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_any) begin
              err_zero <= 1'b1;
            end else begin
              pend      <= in_vec;
              out_multi <= !in_single;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            // Clearing the lowest set bit is exactly the bit currently on out_code.
            pend <= pend & (pend - N_IN'(1));
            if (pend_single) begin
              out_multi <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // pend is zero whenever the block is idle, so code and last fall to 0 there.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_code  = pend_code;
  assign out_last  = pend_single && pend_any;

endmodule

// File: tb/tb_encoder16x4_drain.sv
// Directed bench for encoder16x4_drain with hand-computed expected codes.
module tb_encoder16x4_drain;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_code;
  logic        out_last;
  logic        out_multi;
  logic        err_zero;
  logic        busy;

  int n_chk;
  int n_pass;

  encoder16x4_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_multi (out_multi),
    .err_zero  (err_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready"},  32'(in_ready),  32'd1);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " out_multi"}, 32'(out_multi), 32'd0);
  endtask

  task automatic chk_out(input string tag, input int code, input bit last, input bit multi);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " in_ready"},  32'(in_ready),  32'd0);
    chk({tag, " busy"},      32'(busy),      32'd1);
    chk({tag, " out_code"},  32'(out_code),  32'(code));
    chk({tag, " out_last"},  32'(out_last),  32'(last));
    chk({tag, " out_multi"}, 32'(out_multi), 32'(multi));
  endtask

  task automatic accept(input logic [15:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    #12;
    chk_idle("reset");
    chk("reset out_code", 32'(out_code), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset err_zero", 32'(err_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // One-hot sweep: one code per vector, back to ready two cycles after accept.
    for (int k = 0; k < 16; k++) begin
      accept(16'(1) << k);
      chk_out($sformatf("onehot%0d", k), k, 1'b1, 1'b0);
      step();
      chk_idle($sformatf("onehot%0d end", k));
    end

    // Multi-bit drain 0x8005 -> 0, 2, 15.
    accept(16'h8005);
    chk_out("m8005 c0", 0, 1'b0, 1'b1);
    step();
    chk_out("m8005 c1", 2, 1'b0, 1'b1);
    step();
    chk_out("m8005 c2", 15, 1'b1, 1'b1);
    step();
    chk_idle("m8005 end");

    // Backpressure hold on 0x0030.
    out_ready = 1'b0;
    accept(16'h0030);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("bp hold%0d", i), 4, 1'b0, 1'b1);
      step();
    end
    out_ready = 1'b1;
    chk_out("bp c0", 4, 1'b0, 1'b1);
    step();
    chk_out("bp c1", 5, 1'b1, 1'b1);
    step();
    chk_idle("bp end");
    step();
    chk("bp no extra", 32'(out_valid), 32'd0);

    // All-zero vector.
    accept(16'h0000);
    chk("zero err_zero", 32'(err_zero), 32'd1);
    chk_idle("zero");
    step();
    chk("zero err_zero drop", 32'(err_zero), 32'd0);
    chk_idle("zero after");

    // Reset mid-drain of 0xFFFF after three codes.
    accept(16'hFFFF);
    chk_out("ffff c0", 0, 1'b0, 1'b1);
    step();
    chk_out("ffff c1", 1, 1'b0, 1'b1);
    step();
    chk_out("ffff c2", 2, 1'b0, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    chk_idle("mid reset");
    chk("mid reset out_code", 32'(out_code), 32'd0);
    chk("mid reset out_last", 32'(out_last), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("post reset");
    step();
    chk("post reset quiet", 32'(out_valid), 32'd0);
    accept(16'h0200);
    chk_out("v0200", 9, 1'b1, 1'b0);
    step();
    chk_idle("v0200 end");

    // in_valid held through a drain: new vector waits for IDLE.
    in_valid = 1'b1;
    in_vec   = 16'h0003;
    step();
    in_vec = 16'h0400;
    chk_out("hold c0", 0, 1'b0, 1'b1);
    step();
    chk_out("hold c1", 1, 1'b1, 1'b1);
    step();
    chk_idle("hold gap");
    step();
    in_valid = 1'b0;
    chk_out("hold next", 10, 1'b1, 1'b0);
    step();
    chk_idle("hold end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
